// File: rtl/frame_buffer_gbx_pkg.sv
// Frame buffer gearbox shared types: symbol, word and keep layouts
// used by the 16b->64b write side and the 64b->16b read side.
package frame_buffer_gbx_pkg;

  localparam int SYM_WIDTH     = 16;
  localparam int SYMS_PER_WORD = 4;

  typedef logic [SYM_WIDTH-1:0]                  sym_t;
  typedef logic [SYMS_PER_WORD-1:0][SYM_WIDTH-1:0] word_t;
  typedef logic [SYMS_PER_WORD-1:0][1:0]         keep_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave modports.
// Carries tvalid/tready, tdata, tkeep, tstrb, tlast, tuser, tid, tdest.
interface axi4_stream_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic                   tvalid;
  logic                   tready;
  logic [DATA_WIDTH-1:0]  tdata;
  logic [KEEP_WIDTH-1:0]  tkeep;
  logic [KEEP_WIDTH-1:0]  tstrb;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (
    output tvalid, tdata, tkeep, tstrb,
    output tlast, tuser, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb,
    input  tlast, tuser, tid, tdest,
    output tready
  );
endinterface

// File: rtl/axi4_stream_16b_64b_gbx.sv
// Write-side gearbox: packs 16b stream symbols into 64b words, lane 0 first.
// Ports: clk_i, rst_i (async high), pkt_i 16b slave, pkt_o 64b master.
module axi4_stream_16b_64b_gbx
  import frame_buffer_gbx_pkg::*;
#(
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  axi4_stream_if.slave   pkt_i,
  axi4_stream_if.master  pkt_o
);

  localparam logic [1:0] LAST_LANE = 2'(SYMS_PER_WORD - 1);

  logic [1:0]             fill_q, fill_d;
  word_t                  acc_data_q, acc_data_d;
  keep_t                  acc_keep_q, acc_keep_d;
  keep_t                  acc_strb_q, acc_strb_d;
  logic [TUSER_WIDTH-1:0] acc_user_q, acc_user_d;

  logic                   o_valid_q, o_valid_d;
  word_t                  o_data_q, o_data_d;
  keep_t                  o_keep_q, o_keep_d;
  keep_t                  o_strb_q, o_strb_d;
  logic                   o_last_q, o_last_d;
  logic [TUSER_WIDTH-1:0] o_user_q, o_user_d;
  logic [TID_WIDTH-1:0]   o_id_q, o_id_d;
  logic [TDEST_WIDTH-1:0] o_dest_q, o_dest_d;

  logic                   in_ready;
  logic                   in_hs;
  logic                   out_hs;
  logic                   done;
  word_t                  m_data;
  keep_t                  m_keep;
  keep_t                  m_strb;
  logic [TUSER_WIDTH-1:0] m_user;

  assign in_ready = !o_valid_q || pkt_o.tready;
  assign in_hs    = pkt_i.tvalid && in_ready;
  assign out_hs   = o_valid_q && pkt_o.tready;
  assign done     = in_hs && (fill_q == LAST_LANE || pkt_i.tlast);

  // Accumulator merged with the current symbol; lanes above it zeroed
  always_comb begin
    m_data         = acc_data_q;
    m_keep         = acc_keep_q;
    m_strb         = acc_strb_q;
    m_data[fill_q] = pkt_i.tdata;
    m_keep[fill_q] = pkt_i.tkeep;
    m_strb[fill_q] = pkt_i.tstrb;
    for (int i = 0; i < SYMS_PER_WORD; i++) begin
      if (i > int'(fill_q)) begin
        m_data[i] = '0;
        m_keep[i] = '0;
        m_strb[i] = '0;
      end
    end
    m_user = acc_user_q | pkt_i.tuser;
  end

  always_comb begin
    fill_d     = fill_q;
    acc_data_d = acc_data_q;
    acc_keep_d = acc_keep_q;
    acc_strb_d = acc_strb_q;
    acc_user_d = acc_user_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_keep_d   = o_keep_q;
    o_strb_d   = o_strb_q;
    o_last_d   = o_last_q;
    o_user_d   = o_user_q;
    o_id_d     = o_id_q;
    o_dest_d   = o_dest_q;
    if (in_hs) begin
      if (done) begin
        fill_d     = '0;
        acc_data_d = '0;
        acc_keep_d = '0;
        acc_strb_d = '0;
        acc_user_d = '0;
      end else begin
        fill_d     = fill_q + 2'd1;
        acc_data_d = m_data;
        acc_keep_d = m_keep;
        acc_strb_d = m_strb;
        acc_user_d = m_user;
      end
    end
    // A completion wins over a drain so back-to-back words have no bubble
    if (done) begin
      o_valid_d = 1'b1;
      o_data_d  = m_data;
      o_keep_d  = m_keep;
      o_strb_d  = m_strb;
      o_last_d  = pkt_i.tlast;
      o_user_d  = m_user;
      o_id_d    = pkt_i.tid;
      o_dest_d  = pkt_i.tdest;
    end else if (out_hs) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_q     <= '0;
      acc_data_q <= '0;
      acc_keep_q <= '0;
      acc_strb_q <= '0;
      acc_user_q <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_keep_q   <= '0;
      o_strb_q   <= '0;
      o_last_q   <= 1'b0;
      o_user_q   <= '0;
      o_id_q     <= '0;
      o_dest_q   <= '0;
    end else begin
      fill_q     <= fill_d;
      acc_data_q <= acc_data_d;
      acc_keep_q <= acc_keep_d;
      acc_strb_q <= acc_strb_d;
      acc_user_q <= acc_user_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_keep_q   <= o_keep_d;
      o_strb_q   <= o_strb_d;
      o_last_q   <= o_last_d;
      o_user_q   <= o_user_d;
      o_id_q     <= o_id_d;
      o_dest_q   <= o_dest_d;
    end
  end

  assign pkt_i.tready = in_ready;
  assign pkt_o.tvalid = o_valid_q;
  assign pkt_o.tdata  = o_data_q;
  assign pkt_o.tkeep  = o_keep_q;
  assign pkt_o.tstrb  = o_strb_q;
  assign pkt_o.tlast  = o_last_q;
  assign pkt_o.tuser  = o_user_q;
  assign pkt_o.tid    = o_id_q;
  assign pkt_o.tdest  = o_dest_q;

endmodule

// File: tb/tb_axi4_stream_16b_64b_gbx.sv
// Scoreboard bench for the 16b->64b write-side gearbox.
// Directed vectors; a negedge monitor pops expected words on handshakes.
module tb_axi4_stream_16b_64b_gbx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(16)) s_if ();
  axi4_stream_if #(.DATA_WIDTH(64)) m_if ();

  axi4_stream_16b_64b_gbx #(
    .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .pkt_i(s_if),
    .pkt_o(m_if)
  );

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;
  bit   stall_prev = 1'b0;
  logic [63:0] prev_d;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(logic [63:0] d, logic [7:0] k, logic l, logic u);
    exp_t e;
    e.d = d; e.k = k; e.l = l; e.u = u;
    exp_q.push_back(e);
  endtask

  // Monitor: inputs change just after posedge, so negedge sees stable values
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      chk("tready_rule", 64'(s_if.tready),
          64'(!(m_if.tvalid && !m_if.tready)));
      if (stall_prev && m_if.tvalid)
        chk("stall_stable", m_if.tdata, prev_d);
      stall_prev = m_if.tvalid && !m_if.tready;
      prev_d     = m_if.tdata;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected none", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", m_if.tdata, e.d);
          chk("tkeep", 64'(m_if.tkeep), 64'(e.k));
          chk("tstrb", 64'(m_if.tstrb), 64'(e.k));
          chk("tlast", 64'(m_if.tlast), 64'(e.l));
          chk("tuser", 64'(m_if.tuser), 64'(e.u));
          chk("tid", 64'(m_if.tid), 64'(e.l));
          chk("tdest", 64'(m_if.tdest), 64'(!e.l));
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
  end

  task automatic send(logic [15:0] d, logic [1:0] k, logic l, logic u);
    int t = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tstrb  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tid    = l;
    s_if.tdest  = !l;
    @(negedge clk);
    while (!s_if.tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got tready 0 expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [15:0] ssym(int k);
    return 16'h1000 + 16'(k);
  endfunction

  initial begin
    logic [63:0] w;
    idle();
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tstrb = '0;
    s_if.tid = '0; s_if.tdest = '0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("rst_tdata", m_if.tdata, 64'd0);
    chk("rst_tkeep", 64'(m_if.tkeep), 64'd0);
    chk("rst_tlast", 64'(m_if.tlast), 64'd0);
    chk("rst_tready", 64'(s_if.tready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full word, SOF on first symbol
    push(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 1'b1);
    send(16'h1111, 2'b11, 1'b0, 1'b1);
    send(16'h2222, 2'b11, 1'b0, 1'b0);
    send(16'h3333, 2'b11, 1'b0, 1'b0);
    send(16'h4444, 2'b11, 1'b1, 1'b0);
    chk("latency_valid", 64'(m_if.tvalid), 64'd1);
    idle();
    drain();

    // Short packet, then next packet must start in lane 0
    push(64'h0000_CCCC_BBBB_AAAA, 8'h3F, 1'b1, 1'b0);
    send(16'hAAAA, 2'b11, 1'b0, 1'b0);
    send(16'hBBBB, 2'b11, 1'b0, 1'b0);
    send(16'hCCCC, 2'b11, 1'b1, 1'b0);
    push(64'h0404_0303_0202_0101, 8'hFF, 1'b1, 1'b0);
    send(16'h0101, 2'b11, 1'b0, 1'b0);
    send(16'h0202, 2'b11, 1'b0, 1'b0);
    send(16'h0303, 2'b11, 1'b0, 1'b0);
    send(16'h0404, 2'b11, 1'b1, 1'b0);

    // Null symbol occupies a lane
    push(64'h0000_C3C3_5A5A_A5A5, 8'h33, 1'b1, 1'b0);
    send(16'hA5A5, 2'b11, 1'b0, 1'b0);
    send(16'h5A5A, 2'b00, 1'b0, 1'b0);
    send(16'hC3C3, 2'b11, 1'b1, 1'b0);

    // Mid-word SOF only marks its own word
    push(64'h2004_2003_2002_2001, 8'hFF, 1'b0, 1'b0);
    push(64'h2008_2007_2006_2005, 8'hFF, 1'b0, 1'b1);
    push(64'h200C_200B_200A_2009, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      send(16'h2001 + 16'(i), 2'b11, 1'(i == 11), 1'(i == 6));
    idle();
    drain();

    // Single-symbol packets back to back
    for (int i = 0; i < 5; i++) begin
      push({48'h0, 16'h7000 + 16'(i)}, 8'h03, 1'b1, 1'b0);
      send(16'h7000 + 16'(i), 2'b11, 1'b1, 1'b0);
      chk("b2b_valid", 64'(m_if.tvalid), 64'd1);
    end
    idle();
    drain();

    // 64-symbol stream with random output backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k % 4 == 3) begin
        w = {ssym(k), ssym(k - 1), ssym(k - 2), ssym(k - 3)};
        push(w, 8'hFF, 1'(k == 63), 1'b0);
      end
      send(ssym(k), 2'b11, 1'(k == 63), 1'b0);
    end
    idle();
    drain();
    rand_rdy = 1'b0;
    @(posedge clk);
    #3;
    m_if.tready = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-word discards the partial word and clears outputs
    send(16'hBAD1, 2'b11, 1'b0, 1'b1);
    send(16'hBAD2, 2'b11, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    chk("mrst_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("mrst_tdata", m_if.tdata, 64'd0);
    chk("mrst_tkeep", 64'(m_if.tkeep), 64'd0);
    chk("mrst_tuser", 64'(m_if.tuser), 64'd0);
    chk("mrst_tready", 64'(s_if.tready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(64'hE4E4_E3E3_E2E2_E1E1, 8'hFF, 1'b1, 1'b0);
    send(16'hE1E1, 2'b11, 1'b0, 1'b0);
    send(16'hE2E2, 2'b11, 1'b0, 1'b0);
    send(16'hE3E3, 2'b11, 1'b0, 1'b0);
    send(16'hE4E4, 2'b11, 1'b1, 1'b0);
    idle();
    drain();
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
